// File: rtl/hold_req_pkg.sv
// hold_req_pkg
// Shared constants and types for the EX-stage hold requester:
//   - instruction address and hold-type bus widths
//   - hold-type codes: none / branch / load
//   - jump enable/disable levels, the zero word, and the reset-active level
//   - FSM state encodings
package hold_req_pkg;

    localparam int INST_ADDR_W = 32;
    localparam int HOLD_TYPE_W = 2;

    localparam logic [HOLD_TYPE_W-1:0] HOLD_TYPE_NONE   = 2'd0;
    localparam logic [HOLD_TYPE_W-1:0] HOLD_TYPE_BRANCH = 2'd1;
    localparam logic [HOLD_TYPE_W-1:0] HOLD_TYPE_LOAD   = 2'd2;

    localparam logic [INST_ADDR_W-1:0] ZERO_WORD = 32'h0000_0000;

    localparam logic JUMP_ENABLE  = 1'b1;
    localparam logic JUMP_DISABLE = 1'b0;

    // Reset input is active-low.
    localparam logic RESET_ENABLE = 1'b0;

    typedef enum logic [1:0] {
        HREQ_IDLE     = 2'd0,
        HREQ_MEM_WAIT = 2'd1,
        HREQ_BR_PEND  = 2'd2
    } hreq_state_e;

endpackage

// File: rtl/hold_req_hazard.sv
// hold_req_hazard
// Combinational load-use detector. It flags a hazard when:
//   - the instruction in EX is a load with a non-zero destination, and
//   - the instruction in ID actually reads that register (rs1 or rs2).
// Ports:
//   ex_mem_read_i        EX instruction is a load
//   ex_rd_i              EX destination register
//   id_rs1_i, id_rs2_i   ID source registers
//   id_rs1_used_i        ID instruction reads rs1
//   id_rs2_used_i        ID instruction reads rs2
//   load_use_o           hazard detected
module hold_req_hazard (
    input  logic       ex_mem_read_i,
    input  logic [4:0] ex_rd_i,
    input  logic [4:0] id_rs1_i,
    input  logic [4:0] id_rs2_i,
    input  logic       id_rs1_used_i,
    input  logic       id_rs2_used_i,
    output logic       load_use_o
);

    logic rs1_hit;
    logic rs2_hit;

    assign rs1_hit = id_rs1_used_i && (id_rs1_i == ex_rd_i);
    assign rs2_hit = id_rs2_used_i && (id_rs2_i == ex_rd_i);

    // x0 is never a real dependency.
    assign load_use_o = ex_mem_read_i && (ex_rd_i != 5'd0) && (rs1_hit || rs2_hit);

endmodule

// File: rtl/hold_req.sv
// hold_req
// EX-stage hazard requester feeding the pipeline hold controller. It detects:
//   - load-use data hazards
//   - taken branches/jumps
//   - multi-cycle data-memory waits
// A small FSM tracks memory waits, defers a branch resolved in the same cycle
// a wait starts, and flags a sticky memory timeout. Outputs are Mealy
// (combinational from state and inputs).
// Ports:
//   i_clk, i_reset                       clock, async active-low reset
//   i_ex_mem_read, i_ex_rd               EX load and its destination register
//   i_id_rs1/2, i_id_rs1/2_used          ID source registers and their use
//   i_branch_taken, i_branch_addr        EX taken branch and its target
//   i_mem_req, i_mem_ready               MEM access issued / completed
//   o_hold_type                          none / branch / load
//   o_jump_flag, o_jump_addr             redirect request and target
//   o_mem_timeout                        sticky memory-wait timeout
module hold_req
    import hold_req_pkg::*;
#(
    parameter int MEM_TIMEOUT = 16,
    parameter int CNT_W       = 8
) (
    input  logic                   i_clk,
    input  logic                   i_reset,
    input  logic                   i_ex_mem_read,
    input  logic [4:0]             i_ex_rd,
    input  logic [4:0]             i_id_rs1,
    input  logic [4:0]             i_id_rs2,
    input  logic                   i_id_rs1_used,
    input  logic                   i_id_rs2_used,
    input  logic                   i_branch_taken,
    input  logic [INST_ADDR_W-1:0] i_branch_addr,
    input  logic                   i_mem_req,
    input  logic                   i_mem_ready,
    output logic [HOLD_TYPE_W-1:0] o_hold_type,
    output logic                   o_jump_flag,
    output logic [INST_ADDR_W-1:0] o_jump_addr,
    output logic                   o_mem_timeout
);

    localparam logic [CNT_W-1:0] TIMEOUT_CNT = CNT_W'(MEM_TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);

    hreq_state_e            state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [INST_ADDR_W-1:0] pend_addr_q, pend_addr_d;
    logic                   pend_vld_q, pend_vld_d;
    logic                   timeout_q, timeout_d;

    logic load_use;
    logic mem_stall;

    hold_req_hazard u_hazard (
        .ex_mem_read_i (i_ex_mem_read),
        .ex_rd_i       (i_ex_rd),
        .id_rs1_i      (i_id_rs1),
        .id_rs2_i      (i_id_rs2),
        .id_rs1_used_i (i_id_rs1_used),
        .id_rs2_used_i (i_id_rs2_used),
        .load_use_o    (load_use)
    );

    assign mem_stall = i_mem_req && !i_mem_ready;

    // State register
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (i_reset == RESET_ENABLE) begin
            state_q     <= HREQ_IDLE;
            cnt_q       <= '0;
            pend_addr_q <= ZERO_WORD;
            pend_vld_q  <= 1'b0;
            timeout_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            pend_addr_q <= pend_addr_d;
            pend_vld_q  <= pend_vld_d;
            timeout_q   <= timeout_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        pend_addr_d = pend_addr_q;
        pend_vld_d  = pend_vld_q;
        timeout_d   = timeout_q;
        case (state_q)
            HREQ_IDLE: begin
                if (mem_stall) begin
                    state_d = HREQ_MEM_WAIT;
                    cnt_d   = CNT_ONE;
                    // EX is about to freeze; keep the branch for after the wait.
                    if (i_branch_taken) begin
                        pend_vld_d  = 1'b1;
                        pend_addr_d = i_branch_addr;
                    end
                end
            end
            HREQ_MEM_WAIT: begin
                if (i_mem_ready || (cnt_q == TIMEOUT_CNT)) begin
                    if (!i_mem_ready) begin
                        timeout_d = 1'b1;
                    end
                    cnt_d   = '0;
                    state_d = pend_vld_q ? HREQ_BR_PEND : HREQ_IDLE;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            HREQ_BR_PEND: begin
                // A stall showing up here is picked up from IDLE next cycle.
                state_d     = HREQ_IDLE;
                pend_vld_d  = 1'b0;
                pend_addr_d = ZERO_WORD;
            end
            default: begin
                state_d     = HREQ_IDLE;
                cnt_d       = '0;
                pend_vld_d  = 1'b0;
                pend_addr_d = ZERO_WORD;
            end
        endcase
    end

    // Output logic
    always_comb begin
        o_hold_type = HOLD_TYPE_NONE;
        o_jump_flag = JUMP_DISABLE;
        o_jump_addr = ZERO_WORD;
        // Held in reset the outputs stay quiet regardless of inputs.
        if (i_reset != RESET_ENABLE) begin
            case (state_q)
                HREQ_IDLE: begin
                    if (mem_stall) begin
                        o_hold_type = HOLD_TYPE_LOAD;
                    end else if (i_branch_taken) begin
                        // The ID instruction is flushed, so branch beats load-use.
                        o_hold_type = HOLD_TYPE_BRANCH;
                        o_jump_flag = JUMP_ENABLE;
                        o_jump_addr = i_branch_addr;
                    end else if (load_use) begin
                        o_hold_type = HOLD_TYPE_LOAD;
                    end
                end
                HREQ_MEM_WAIT: begin
                    o_hold_type = HOLD_TYPE_LOAD;
                end
                HREQ_BR_PEND: begin
                    o_hold_type = HOLD_TYPE_BRANCH;
                    o_jump_flag = JUMP_ENABLE;
                    o_jump_addr = pend_addr_q;
                end
                default: begin
                    o_hold_type = HOLD_TYPE_NONE;
                end
            endcase
        end
    end

    assign o_mem_timeout = timeout_q;

endmodule

// File: tb/tb_hold_req.sv
module tb_hold_req;
    import hold_req_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        ex_mem_read;
    logic [4:0]  ex_rd, id_rs1, id_rs2;
    logic        rs1_used, rs2_used;
    logic        br_taken;
    logic [31:0] br_addr;
    logic        mem_req, mem_ready;
    logic [1:0]  hold_type;
    logic        jump_flag;
    logic [31:0] jump_addr;
    logic        mem_timeout;

    always #5 clk = ~clk;

    hold_req #(.MEM_TIMEOUT(16), .CNT_W(8)) dut (
        .i_clk          (clk),
        .i_reset        (rst_n),
        .i_ex_mem_read  (ex_mem_read),
        .i_ex_rd        (ex_rd),
        .i_id_rs1       (id_rs1),
        .i_id_rs2       (id_rs2),
        .i_id_rs1_used  (rs1_used),
        .i_id_rs2_used  (rs2_used),
        .i_branch_taken (br_taken),
        .i_branch_addr  (br_addr),
        .i_mem_req      (mem_req),
        .i_mem_ready    (mem_ready),
        .o_hold_type    (hold_type),
        .o_jump_flag    (jump_flag),
        .o_jump_addr    (jump_addr),
        .o_mem_timeout  (mem_timeout)
    );

    typedef struct packed {
        logic [1:0]  ht;
        logic        jf;
        logic [31:0] ja;
        logic        to;
    } exp_t;

    exp_t sb_q[$];
    int   err_cnt = 0;
    int   chk_cnt = 0;

    task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
        chk_cnt++;
        if (act !== exp) begin
            err_cnt++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic idle_in();
        ex_mem_read = 1'b0; ex_rd = 5'd0; id_rs1 = 5'd0; id_rs2 = 5'd0;
        rs1_used = 1'b0; rs2_used = 1'b0;
        br_taken = 1'b0; br_addr = 32'h0;
        mem_req = 1'b0; mem_ready = 1'b0;
    endtask

    task automatic push_exp(input logic [1:0] ht, input logic jf, input logic [31:0] ja, input logic to);
        exp_t e;
        e.ht = ht; e.jf = jf; e.ja = ja; e.to = to;
        sb_q.push_back(e);
    endtask

    task automatic pop_cmp(input string tag);
        exp_t e;
        e = sb_q.pop_front();
        check_val({tag, "_ht"}, 32'(hold_type), 32'(e.ht));
        check_val({tag, "_jf"}, 32'(jump_flag), 32'(e.jf));
        check_val({tag, "_ja"}, jump_addr, e.ja);
        check_val({tag, "_to"}, 32'(mem_timeout), 32'(e.to));
        $display("%-10s ht=%0d jf=%0d ja=0x%08h to=%0d", tag, hold_type, jump_flag, jump_addr, mem_timeout);
    endtask

    // Inputs are already set; expect, sample mid-cycle, advance to next cycle.
    task automatic cyc(input string tag, input logic [1:0] ht, input logic jf,
                       input logic [31:0] ja, input logic to);
        push_exp(ht, jf, ja, to);
        #4;
        pop_cmp(tag);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        idle_in();
        rst_n = 1'b0;
        @(posedge clk); @(posedge clk); #1;

        // Reset state: a taken branch must not leak out while in reset
        br_taken = 1'b1; br_addr = 32'h100;
        cyc("rst", HOLD_TYPE_NONE, 1'b0, 32'h0, 1'b0);
        idle_in();
        rst_n = 1'b1;
        cyc("idle", HOLD_TYPE_NONE, 1'b0, 32'h0, 1'b0);

        // Load-use via rs2, exactly one cycle
        ex_mem_read = 1'b1; ex_rd = 5'd5; id_rs2 = 5'd5; rs2_used = 1'b1;
        cyc("lu_rs2", HOLD_TYPE_LOAD, 1'b0, 32'h0, 1'b0);
        idle_in();
        cyc("lu_after", HOLD_TYPE_NONE, 1'b0, 32'h0, 1'b0);
        // rd = x0 is no hazard
        ex_mem_read = 1'b1; ex_rd = 5'd0; id_rs2 = 5'd0; rs2_used = 1'b1;
        cyc("lu_x0", HOLD_TYPE_NONE, 1'b0, 32'h0, 1'b0);
        // rs1 match, then the same match with rs1 unused
        idle_in();
        ex_mem_read = 1'b1; ex_rd = 5'd7; id_rs1 = 5'd7; rs1_used = 1'b1;
        cyc("lu_rs1", HOLD_TYPE_LOAD, 1'b0, 32'h0, 1'b0);
        rs1_used = 1'b0;
        cyc("lu_unused", HOLD_TYPE_NONE, 1'b0, 32'h0, 1'b0);
        // Not a load
        ex_mem_read = 1'b0; rs1_used = 1'b1;
        cyc("lu_noload", HOLD_TYPE_NONE, 1'b0, 32'h0, 1'b0);

        // Branch, then branch + load-use (branch wins)
        idle_in();
        br_taken = 1'b1; br_addr = 32'h0000_0100;
        cyc("br", HOLD_TYPE_BRANCH, 1'b1, 32'h100, 1'b0);
        ex_mem_read = 1'b1; ex_rd = 5'd5; id_rs2 = 5'd5; rs2_used = 1'b1;
        br_addr = 32'h0000_0140;
        cyc("br_lu", HOLD_TYPE_BRANCH, 1'b1, 32'h140, 1'b0);
        idle_in();
        cyc("br_after", HOLD_TYPE_NONE, 1'b0, 32'h0, 1'b0);

        // Memory wait: 4 cycles not ready, then ready -> 5 load cycles
        mem_req = 1'b1;
        cyc("mw0", HOLD_TYPE_LOAD, 1'b0, 32'h0, 1'b0);
        cyc("mw1", HOLD_TYPE_LOAD, 1'b0, 32'h0, 1'b0);
        br_taken = 1'b1; br_addr = 32'h300;   // ignored while EX is frozen
        cyc("mw2_br", HOLD_TYPE_LOAD, 1'b0, 32'h0, 1'b0);
        br_taken = 1'b0; br_addr = 32'h0;
        cyc("mw3", HOLD_TYPE_LOAD, 1'b0, 32'h0, 1'b0);
        mem_ready = 1'b1;
        cyc("mw_rdy", HOLD_TYPE_LOAD, 1'b0, 32'h0, 1'b0);
        idle_in();
        cyc("mw_done", HOLD_TYPE_NONE, 1'b0, 32'h0, 1'b0);
        // Access completing in the same cycle it is issued: no stall
        mem_req = 1'b1; mem_ready = 1'b1;
        cyc("mem_fast", HOLD_TYPE_NONE, 1'b0, 32'h0, 1'b0);

        // Deferred branch
        idle_in();
        mem_req = 1'b1; br_taken = 1'b1; br_addr = 32'h0000_0200;
        cyc("db_start", HOLD_TYPE_LOAD, 1'b0, 32'h0, 1'b0);
        br_taken = 1'b0; br_addr = 32'h0;
        cyc("db_w1", HOLD_TYPE_LOAD, 1'b0, 32'h0, 1'b0);
        cyc("db_w2", HOLD_TYPE_LOAD, 1'b0, 32'h0, 1'b0);
        mem_ready = 1'b1;
        cyc("db_rdy", HOLD_TYPE_LOAD, 1'b0, 32'h0, 1'b0);
        idle_in();
        cyc("db_jump", HOLD_TYPE_BRANCH, 1'b1, 32'h200, 1'b0);
        cyc("db_after", HOLD_TYPE_NONE, 1'b0, 32'h0, 1'b0);

        // Deferred branch with a new stall arriving during BR_PEND
        mem_req = 1'b1; br_taken = 1'b1; br_addr = 32'h0000_0240;
        cyc("db2_start", HOLD_TYPE_LOAD, 1'b0, 32'h0, 1'b0);
        br_taken = 1'b0; br_addr = 32'h0; mem_ready = 1'b1;
        cyc("db2_rdy", HOLD_TYPE_LOAD, 1'b0, 32'h0, 1'b0);
        mem_ready = 1'b0;
        cyc("db2_jump", HOLD_TYPE_BRANCH, 1'b1, 32'h240, 1'b0);
        cyc("db2_stall", HOLD_TYPE_LOAD, 1'b0, 32'h0, 1'b0);
        mem_ready = 1'b1;
        cyc("db2_rdy2", HOLD_TYPE_LOAD, 1'b0, 32'h0, 1'b0);
        idle_in();
        cyc("db2_after", HOLD_TYPE_NONE, 1'b0, 32'h0, 1'b0);

        // Timeout: ready never comes. Stall cycle plus 16 wait cycles held.
        mem_req = 1'b1;
        for (int i = 0; i < 17; i++) begin
            cyc($sformatf("to_w%0d", i), HOLD_TYPE_LOAD, 1'b0, 32'h0, 1'b0);
        end
        idle_in();
        cyc("to_rel", HOLD_TYPE_NONE, 1'b0, 32'h0, 1'b1);
        cyc("to_sticky", HOLD_TYPE_NONE, 1'b0, 32'h0, 1'b1);
        mem_req = 1'b1;
        cyc("to_w_a", HOLD_TYPE_LOAD, 1'b0, 32'h0, 1'b1);
        cyc("to_w_b", HOLD_TYPE_LOAD, 1'b0, 32'h0, 1'b1);

        // Async reset asserted mid-cycle while waiting
        push_exp(HOLD_TYPE_NONE, 1'b0, 32'h0, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        pop_cmp("rst_mid");
        @(posedge clk); #1;
        idle_in();
        rst_n = 1'b1;
        cyc("rst_rel", HOLD_TYPE_NONE, 1'b0, 32'h0, 1'b0);
        // After reset the FSM is back in IDLE: branch goes out directly
        br_taken = 1'b1; br_addr = 32'h0000_0380;
        cyc("rst_br", HOLD_TYPE_BRANCH, 1'b1, 32'h380, 1'b0);
        idle_in();
        cyc("end", HOLD_TYPE_NONE, 1'b0, 32'h0, 1'b0);

        check_val("sb_empty", 32'(sb_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
        $finish;
    end

endmodule
